// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    BLANK = 3'd2,
    SEND  = 3'd3,
    GAP   = 3'd4
  } tx_sched_state_e;

  // Start bit, 8 data bits and stop bit.
  localparam int FRAME_BITS = 10;
  // Bit periods allowed in SEND before the frame is declared lost.
  localparam int TMO_BITS   = 12;
  // Cycles after tx_start during which a stale tx_done is ignored.
  localparam int DONE_BLANK = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the last winner,
// wrapping modulo N. Purely combinational, so the caller owns the pointer.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int W = $clog2(N);

  logic [W-1:0] idx;
  logic         found;

  // Scan N positions starting one past the last winner; first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = last;
    for (int k = 1; k <= N; k++) begin
      idx = W'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 UART transmitter between N_REQ
// byte producers. Grants a requester, strobes the byte into the
// transmitter, generates the baud tick, then waits for tx_done (with a
// timeout) and an optional idle gap before re-arbitrating.
//
// Handshake: req_valid[i] with its byte is held by the producer until the
// one-cycle req_ready[i] pulse; the byte is taken in that cycle. req_valid is
// only sampled in IDLE, so a producer may withdraw any time before its pulse.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200,
  parameter int GAP_BITS = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic                     tx_en,
  input  logic                     tx_done,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     err_tmo,
  output logic [2:0]               state_dbg
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int GW       = $clog2(N_REQ);
  localparam int BW       = $clog2(BAUD_DIV);
  localparam int TMO_CYC  = TMO_BITS * BAUD_DIV;
  localparam int GAP_CYC  = GAP_BITS * BAUD_DIV;
  localparam int CNT_MAX  = max_int(TMO_BITS, GAP_BITS) * BAUD_DIV;
  localparam int CW       = $clog2(CNT_MAX);

  localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TMO_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CW-1:0] BLANK_LAST = CW'(DONE_BLANK - 1);

  if (BAUD_DIV < 2 || N_REQ < 2 || N_REQ > 8 || GAP_BITS < 0 || GAP_BITS > 15) begin : g_bad_cfg
    $error("uart_tx_sched: unsupported parameter combination");
  end

  tx_sched_state_e state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [GW-1:0]    arb_idx;
  logic [7:0]       req_byte [N_REQ];

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .last    (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Split the flat data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_byte[i] = req_data[8*i +: 8];
    end
  end

  // Next-state logic and all strobes; cnt_q is shared by BLANK, SEND and GAP.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    tx_data_d = tx_data_q;
    baud_d    = baud_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    tx_start  = 1'b0;
    tx_data   = tx_data_q;
    tx_en     = 1'b0;
    err_tmo   = 1'b0;

    // Baud divider runs only while a frame is on the line.
    if (state_q == BLANK || state_q == SEND) begin
      if (baud_q == BAUD_LAST) begin
        tx_en  = 1'b1;
        baud_d = '0;
      end else begin
        baud_d = baud_q + BW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          grant_d = arb_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        req_ready[grant_q] = 1'b1;
        tx_start           = 1'b1;
        tx_data            = req_byte[grant_q];
        tx_data_d          = req_byte[grant_q];
        ptr_d              = grant_q;
        baud_d             = '0;
        cnt_d              = '0;
        state_d            = BLANK;
      end
      BLANK: begin
        // tx_done may still be high from the previous frame here.
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = SEND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SEND: begin
        if (tx_done) begin
          cnt_d   = '0;
          state_d = (GAP_BITS > 0) ? GAP : IDLE;
        end else if (cnt_q == TMO_LAST) begin
          err_tmo = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset leaves requester 0 with first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= GW'(N_REQ - 1);
      tx_data_q <= '0;
      baud_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      tx_data_q <= tx_data_d;
      baud_q    <= baud_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: instance a (no gap) and instance b (GAP_BITS=2),
// each driven into a small behavioural 8N1 transmitter model that holds
// tx_done as a level until two cycles after the next tx_start.
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int N_REQ    = 4;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int GAP_B    = 2;
  // LOAD -> 10th tick is FRAME_BITS*DIV cycles; model raises done one cycle
  // later, the FSM leaves SEND one cycle after that, and IDLE takes one more.
  localparam int FALL_AFTER_START = FRAME_BITS * DIV + 2;
  localparam int START_SPACING    = FRAME_BITS * DIV + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, rst_b;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT a ----------------
  logic [N_REQ-1:0]   req_valid_a, req_ready_a;
  logic [8*N_REQ-1:0] req_data_a;
  logic               tx_start_a, tx_en_a, tx_done_a, busy_a, err_tmo_a;
  logic [7:0]         tx_data_a;
  logic [1:0]         grant_id_a;
  logic [2:0]         state_dbg_a;

  uart_tx_sched #(.N_REQ(N_REQ), .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .GAP_BITS(0)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_data(req_data_a),
    .req_ready(req_ready_a), .tx_start(tx_start_a), .tx_data(tx_data_a), .tx_en(tx_en_a),
    .tx_done(tx_done_a), .busy(busy_a), .grant_id(grant_id_a), .err_tmo(err_tmo_a),
    .state_dbg(state_dbg_a)
  );

  // ---------------- DUT b ----------------
  logic [N_REQ-1:0]   req_valid_b, req_ready_b;
  logic [8*N_REQ-1:0] req_data_b;
  logic               tx_start_b, tx_en_b, tx_done_b, busy_b, err_tmo_b;
  logic [7:0]         tx_data_b;
  logic [1:0]         grant_id_b;
  logic [2:0]         state_dbg_b;

  uart_tx_sched #(.N_REQ(N_REQ), .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .GAP_BITS(GAP_B)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(req_valid_b), .req_data(req_data_b),
    .req_ready(req_ready_b), .tx_start(tx_start_b), .tx_data(tx_data_b), .tx_en(tx_en_b),
    .tx_done(tx_done_b), .busy(busy_b), .grant_id(grant_id_b), .err_tmo(err_tmo_b),
    .state_dbg(state_dbg_b)
  );

  // ---------------- transmitter model (index 0 = a, 1 = b) ----------------
  logic [1:0] m_rst, m_start, m_en, m_done, m_never;
  logic [7:0] m_data [2];
  logic [9:0] m_sh   [2];
  int         m_bits [2];
  int         m_hold [2];

  assign m_rst     = {rst_b, rst};
  assign m_start   = {tx_start_b, tx_start_a};
  assign m_en      = {tx_en_b, tx_en_a};
  assign m_data[0] = tx_data_a;
  assign m_data[1] = tx_data_b;
  assign tx_done_a = m_done[0];
  assign tx_done_b = m_done[1];

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (m_rst[c]) begin
        m_done[c] <= 1'b0;
        m_hold[c] <= 0;
        m_bits[c] <= 0;
        m_sh[c]   <= '1;
      end else if (m_start[c]) begin
        m_sh[c]   <= {1'b1, m_data[c], 1'b0};
        m_bits[c] <= 0;
        m_hold[c] <= DONE_BLANK;
      end else begin
        if (m_hold[c] == 1) m_done[c] <= 1'b0;
        if (m_hold[c] != 0) m_hold[c] <= m_hold[c] - 1;
        if (m_en[c]) begin
          m_sh[c]   <= {1'b1, m_sh[c][9:1]};
          m_bits[c] <= m_bits[c] + 1;
          if (m_bits[c] == FRAME_BITS - 1 && !m_never[c]) m_done[c] <= 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];   // {grant, byte} expected at each tx_start of a
  logic [9:0] exp_qb[$];  // same for b
  logic       line_q[$];  // expected line bit at each tick of a
  int         st_q_a[$], st_q_b[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  int   last_start_a = 0, tick_cnt_a = 0, tmo_cnt_a = 0, tmo_cyc_a = 0;
  int   done_rise_a = 0, fall_cyc_a = 0, fall_cyc_b = 0, gap_ticks_b = 0;
  logic done_prev_a = 1'b0, busy_prev_a = 1'b0, busy_prev_b = 1'b0;
  logic [9:0] e_a, e_b;
  logic       lb;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start_a) begin
        st_q_a.push_back(cyc);
        last_start_a = cyc;
        tick_cnt_a   = 0;
        check("sb_a_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e_a = exp_q.pop_front();
          check("grant_a", grant_id_a, e_a[9:8]);
          check("data_a", tx_data_a, e_a[7:0]);
          check("ready_a", req_ready_a, 4'b0001 << e_a[9:8]);
        end
      end else if (req_ready_a != 0) begin
        check("ready_without_start_a", req_ready_a, 0);
      end
      if (tx_en_a) begin
        tick_cnt_a++;
        check("tx_en_phase_a", (state_dbg_a == BLANK) || (state_dbg_a == SEND), 1);
        if (line_q.size() != 0) begin
          lb = line_q.pop_front();
          check("line_bit_a", m_sh[0][0], lb);
        end
      end
      if (err_tmo_a) begin
        tmo_cnt_a++;
        tmo_cyc_a = cyc;
      end
      if (tx_done_a && !done_prev_a) done_rise_a = cyc;
      if (busy_prev_a && !busy_a) fall_cyc_a = cyc;
    end
    done_prev_a = tx_done_a;
    busy_prev_a = busy_a;
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      if (tx_start_b) begin
        st_q_b.push_back(cyc);
        check("sb_b_nonempty", exp_qb.size() != 0, 1);
        if (exp_qb.size() != 0) begin
          e_b = exp_qb.pop_front();
          check("grant_b", grant_id_b, e_b[9:8]);
          check("data_b", tx_data_b, e_b[7:0]);
        end
      end
      if (tx_en_b && state_dbg_b == GAP) gap_ticks_b++;
      if (busy_prev_b && !busy_b) fall_cyc_b = cyc;
    end
    busy_prev_b = busy_b;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req_a(input int i, input logic [7:0] d);
    req_data_a[8*i +: 8] = d;
    req_valid_a[i]       = 1'b1;
    exp_q.push_back({i[1:0], d});
  endtask

  task automatic drive_req_b(input int i, input logic [7:0] d);
    req_data_b[8*i +: 8] = d;
    req_valid_b[i]       = 1'b1;
    exp_qb.push_back({i[1:0], d});
  endtask

  // Wait for requester i's ready pulse on a, then withdraw its valid.
  task automatic wait_ready_a(input int i, input int budget);
    int t = 0;
    while (req_ready_a[i] !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait_a", req_ready_a[i], 1);
    @(posedge clk); #1;
    req_valid_a[i] = 1'b0;
  endtask

  task automatic wait_ready_b(input int i, input int budget);
    int t = 0;
    while (req_ready_b[i] !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait_b", req_ready_b[i], 1);
    @(posedge clk); #1;
    req_valid_b[i] = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int t = 0;
    while (busy_a !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait_a", busy_a, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle_b(input int budget);
    int t = 0;
    while (busy_b !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait_b", busy_b, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_a();
    check("rst_req_ready", req_ready_a, 0);
    check("rst_tx_start", tx_start_a, 0);
    check("rst_tx_data", tx_data_a, 0);
    check("rst_tx_en", tx_en_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_grant_id", grant_id_a, 0);
    check("rst_err_tmo", err_tmo_a, 0);
    check("rst_state", state_dbg_a, IDLE);
  endtask

  task automatic do_reset_a();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    st_q_a.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int t;
    logic [7:0] line_bits [10];
    rst = 1'b1; rst_b = 1'b1;
    req_valid_a = '0; req_data_a = '0;
    req_valid_b = '0; req_data_b = '0;
    m_never = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_a();
    @(posedge clk); #1;
    rst = 1'b0; rst_b = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 1: single request from requester 2, byte 0xA5, checked on the line.
    line_bits = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1};
    for (int k = 0; k < 10; k++) line_q.push_back(line_bits[k][0]);
    t = cyc;
    drive_req_a(2, 8'hA5);
    wait_ready_a(2, 10);
    wait_idle_a(200);
    check("latency_a", last_start_a - t, 1);
    check("ticks_single", tick_cnt_a, FRAME_BITS);
    check("busy_fall_after_done", fall_cyc_a - done_rise_a, 1);
    check("line_bits_left", line_q.size(), 0);

    // 2: all four held valid from reset -> grants 0,1,2,3,0.
    do_reset_a();
    req_data_a  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 5; k++) exp_q.push_back({k[1:0], 8'h10 + 8'(k % 4)});
    req_valid_a = 4'hF;
    t = 0;
    while (st_q_a.size() < 5 && t < 700) begin
      @(negedge clk);
      t++;
    end
    check("rr_five_starts", st_q_a.size() >= 5, 1);
    @(posedge clk); #1;
    req_valid_a = '0;
    wait_idle_a(200);
    for (int k = 0; k + 1 < st_q_a.size(); k++)
      check("rr_spacing", st_q_a[k+1] - st_q_a[k], START_SPACING);

    // 3: tx_done still high from the previous frame must not end this one.
    check("stale_done_level", tx_done_a, 1);
    drive_req_a(1, 8'h99);
    wait_ready_a(1, 10);
    wait_idle_a(200);
    check("ticks_stale", tick_cnt_a, FRAME_BITS);
    check("busy_len_stale", fall_cyc_a - last_start_a, FALL_AFTER_START);

    // 4: transmitter never reports done -> timeout in the 120th SEND cycle.
    m_never[0] = 1'b1;
    drive_req_a(1, 8'h3C);
    wait_ready_a(1, 10);
    wait_idle_a(300);
    check("tmo_pulses", tmo_cnt_a, 1);
    check("tmo_time", tmo_cyc_a - last_start_a, DONE_BLANK + 1 + TMO_BITS * DIV - 1);
    check("tmo_to_idle", fall_cyc_a - tmo_cyc_a, 1);
    m_never[0] = 1'b0;
    drive_req_a(3, 8'h5A);
    wait_ready_a(3, 10);
    wait_idle_a(200);
    check("ticks_after_tmo", tick_cnt_a, FRAME_BITS);
    check("tmo_no_repeat", tmo_cnt_a, 1);

    // Random single requests.
    for (int k = 0; k < 3; k++) begin
      int r;
      r = $urandom_range(0, N_REQ - 1);
      drive_req_a(r, 8'($urandom_range(0, 255)));
      wait_ready_a(r, 10);
      wait_idle_a(200);
      check("ticks_rand", tick_cnt_a, FRAME_BITS);
    end

    // 5: GAP_BITS=2 instance, two requests back to back.
    drive_req_b(0, 8'h81);
    drive_req_b(1, 8'h42);
    wait_ready_b(0, 10);
    wait_ready_b(1, 400);
    wait_idle_b(400);
    check("gap_starts", st_q_b.size(), 2);
    if (st_q_b.size() == 2)
      check("gap_spacing", st_q_b[1] - st_q_b[0], START_SPACING + GAP_B * DIV);
    check("gap_busy_len", fall_cyc_b - st_q_b[st_q_b.size()-1], FALL_AFTER_START + GAP_B * DIV);
    check("gap_tx_en", gap_ticks_b, 0);

    // 6: reset in the middle of SEND, then 0 and 3 requesting together.
    drive_req_a(2, 8'hC3);
    wait_ready_a(2, 10);
    t = 0;
    while (state_dbg_a != SEND && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("reach_send", state_dbg_a, SEND);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    req_data_a[7:0]   = 8'h77;
    req_data_a[31:24] = 8'hEE;
    req_valid_a       = 4'b1001;
    @(posedge clk);
    @(negedge clk);
    check_reset_a();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back({2'd0, 8'h77});
    exp_q.push_back({2'd3, 8'hEE});
    wait_ready_a(0, 10);
    wait_ready_a(3, 400);
    wait_idle_a(200);

    check("sb_a_drained", exp_q.size(), 0);
    check("sb_b_drained", exp_qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
